// File: rtl/snn_pkg.sv
// Shared definitions for the spiking perceptron.
//   - state_t           : sample FSM states
//   - NEU_*             : neuron_out encodings (bit1 positive, bit0 negative)
//   - balance_width()   : membrane balance width for a given weight width
//   - delta_width()     : signed width of one column's weighted sum
//   - sat_max/sat_min() : saturation bounds of the balance
//   - offset_to_signed(): offset-binary weight (zero = 2^width) to signed int
package snn_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [1:0] NEU_NONE = 2'b00;
   localparam logic [1:0] NEU_NEG  = 2'b01;
   localparam logic [1:0] NEU_POS  = 2'b10;

   function automatic int balance_width(input int width);
      return width + 3;
   endfunction

   // One weight is width+1 bits signed; summing height of them needs
   // clog2(height) more bits.
   function automatic int delta_width(input int width, input int height);
      return width + 2 + $clog2(height);
   endfunction

   function automatic int sat_max(input int width);
      return (1 << (width + 2)) - 1;
   endfunction

   function automatic int sat_min(input int width);
      return -(1 << (width + 2));
   endfunction

   function automatic int offset_to_signed(input int raw, input int width);
      return raw - (1 << width);
   endfunction

endpackage

// File: rtl/snn_weighted_sum.sv
// Combinational signed sum of the weights of the active pixels.
//   pixels : HEIGHT-bit column, pixels[i] selects WEIGHTS[i]
//   delta  : signed sum, delta_width(WIDTH, HEIGHT) bits
module snn_weighted_sum
   import snn_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 7,
   parameter logic [WIDTH:0] WEIGHTS [HEIGHT] = '{default: (WIDTH+1)'(1 << WIDTH)}
) (
   input  logic [HEIGHT-1:0]                          pixels,
   output logic signed [delta_width(WIDTH, HEIGHT)-1:0] delta
);

   localparam int DW = delta_width(WIDTH, HEIGHT);

   // Weights are parameters, so each signed term folds to a constant.
   always_comb begin
      delta = '0;
      for (int i = 0; i < HEIGHT; i++) begin
         if (pixels[i]) begin
            delta = delta + DW'(offset_to_signed(int'(WEIGHTS[i]), WIDTH));
         end
      end
   end

endmodule

// File: rtl/run_network.sv
// Single neuron-pair spiking perceptron.
//   clk         : rising-edge clock
//   rst_n       : synchronous active-low reset
//   start       : pulse, clears balance and begins a sample
//   pixels      : current pixel column, 1 = active
//   neuron_out  : registered spikes, bit1 positive, bit0 negative
//   balance_out : registered signed membrane balance (WIDTH+3 bits)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; balance held, no spikes, pixels ignored
// RUN   | accumulating one column per edge, spiking on threshold crossing
module run_network
   import snn_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int HEIGHT    = 7,
   parameter logic [WIDTH:0] WEIGHTS [HEIGHT] = '{default: (WIDTH+1)'(1 << WIDTH)},
   parameter int THRESHOLD = 256
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [HEIGHT-1:0]                pixels,
   output logic [1:0]                       neuron_out,
   output logic [balance_width(WIDTH)-1:0]  balance_out
);

   localparam int BW = balance_width(WIDTH);
   localparam int DW = delta_width(WIDTH, HEIGHT);
   // One extra bit over the wider operand so balance + delta never wraps
   // before saturation is applied.
   localparam int AW = ((DW > BW) ? DW : BW) + 1;

   localparam logic signed [AW-1:0] SAT_HI  = AW'(sat_max(WIDTH));
   localparam logic signed [AW-1:0] SAT_LO  = AW'(sat_min(WIDTH));
   localparam logic signed [AW-1:0] THR_POS = AW'(THRESHOLD);
   localparam logic signed [AW-1:0] THR_NEG = AW'(-THRESHOLD);

   state_t                  state_q;
   state_t                  state_d;
   logic [BW-1:0]           bal_d;
   logic [1:0]              neu_d;
   logic signed [DW-1:0]    delta;
   logic signed [AW-1:0]    acc_raw;
   logic signed [AW-1:0]    acc_sat;

   snn_weighted_sum #(
      .WIDTH   (WIDTH),
      .HEIGHT  (HEIGHT),
      .WEIGHTS (WEIGHTS)
   ) u_sum (
      .pixels (pixels),
      .delta  (delta)
   );

   always_comb begin
      acc_raw = AW'($signed(balance_out)) + AW'(delta);
      if (acc_raw > SAT_HI) begin
         acc_sat = SAT_HI;
      end else if (acc_raw < SAT_LO) begin
         acc_sat = SAT_LO;
      end else begin
         acc_sat = acc_raw;
      end
   end

   always_comb begin
      state_d = state_q;
      bal_d   = balance_out;
      neu_d   = NEU_NONE;
      case (state_q)
         IDLE: begin
            if (start) begin
               bal_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (start) begin
               bal_d = '0;
            end else if (acc_sat >= THR_POS) begin
               bal_d = BW'(acc_sat - THR_POS);
               neu_d = NEU_POS;
            end else if (acc_sat <= THR_NEG) begin
               bal_d = BW'(acc_sat - THR_NEG);
               neu_d = NEU_NEG;
            end else begin
               bal_d = BW'(acc_sat);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         balance_out <= '0;
         neuron_out  <= NEU_NONE;
      end else begin
         state_q     <= state_d;
         balance_out <= bal_d;
         neuron_out  <= neu_d;
      end
   end

endmodule

// File: tb/tb_run_network.sv
module tb_run_network;

   localparam int WIDTH  = 8;
   localparam int HEIGHT = 7;
   localparam int THR    = 256;
   // Signed weights -1, +127, +129, +66 x4: columns 0000111 -> +255,
   // 1111111 -> +519, 0000001 -> -1.
   localparam logic [WIDTH:0] TB_W [HEIGHT] =
      '{9'd255, 9'd383, 9'd385, 9'd322, 9'd322, 9'd322, 9'd322};

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [HEIGHT-1:0] pixels;
   logic [1:0]        neuron_out;
   logic [WIDTH+2:0]  balance_out;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   bit m_run;
   int m_bal;
   int m_neu;

   run_network #(
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT),
      .WEIGHTS   (TB_W),
      .THRESHOLD (THR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pixels      (pixels),
      .neuron_out  (neuron_out),
      .balance_out (balance_out)
   );

   always #5 clk = ~clk;

   function automatic int col_sum(input logic [HEIGHT-1:0] p);
      int s = 0;
      for (int i = 0; i < HEIGHT; i++)
         if (p[i]) s += int'(TB_W[i]) - 256;
      return s;
   endfunction

   task automatic model_edge(input bit r, input bit s, input logic [HEIGHT-1:0] p);
      int a;
      if (!r) begin
         m_run = 0; m_bal = 0; m_neu = 0;
      end else if (!m_run) begin
         m_neu = 0;
         if (s) begin m_run = 1; m_bal = 0; end
      end else if (s) begin
         m_bal = 0; m_neu = 0;
      end else begin
         a = m_bal + col_sum(p);
         if (a > 1023) a = 1023;
         if (a < -1024) a = -1024;
         if (a >= THR)       begin m_bal = a - THR; m_neu = 2; end
         else if (a <= -THR) begin m_bal = a + THR; m_neu = 1; end
         else                begin m_bal = a;       m_neu = 0; end
      end
   endtask

   task automatic apply(input bit r, input bit s, input logic [HEIGHT-1:0] p);
      @(negedge clk);
      rst_n = r; start = s; pixels = p;
      @(posedge clk);
      #1;
      model_edge(r, s, p);
   endtask

   function automatic int dut_bal();
      return int'($signed(balance_out));
   endfunction

   task automatic test_reset();
      apply(0, 1, 7'h7F);
      apply(0, 1, 7'h7F);
      vectors++;
      if (dut_bal() !== 0 || neuron_out !== 2'b00) begin
         miscompares++;
         $display("FAIL reset: got bal=%0d out=%b, expected bal=0 out=00", dut_bal(), neuron_out);
      end
   endtask

   task automatic test_idle_hold();
      apply(0, 0, 7'h7F);
      for (int i = 0; i < 20; i++) begin
         apply(1, 0, 7'h7F);
         vectors++;
         if (dut_bal() !== 0 || neuron_out !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_hold[%0d]: got bal=%0d out=%b, expected bal=0 out=00", i, dut_bal(), neuron_out);
         end
      end
   endtask

   task automatic test_pos_small();
      int exp_b [3] = '{255, 254, 253};
      logic [1:0] exp_o [3] = '{2'b00, 2'b10, 2'b10};
      apply(1, 1, 7'b0000111);
      for (int i = 0; i < 3; i++) begin
         apply(1, 0, 7'b0000111);
         vectors++;
         if (dut_bal() !== exp_b[i] || neuron_out !== exp_o[i]) begin
            miscompares++;
            $display("FAIL pos_small[%0d]: got bal=%0d out=%b, expected bal=%0d out=%b",
                     i, dut_bal(), neuron_out, exp_b[i], exp_o[i]);
         end
      end
   endtask

   task automatic test_saturate();
      int exp_b [6] = '{263, 526, 767, 767, 767, 767};
      apply(1, 1, 7'h7F);
      for (int i = 0; i < 6; i++) begin
         apply(1, 0, 7'h7F);
         vectors++;
         if (dut_bal() !== exp_b[i] || neuron_out !== 2'b10) begin
            miscompares++;
            $display("FAIL saturate[%0d]: got bal=%0d out=%b, expected bal=%0d out=10",
                     i, dut_bal(), neuron_out, exp_b[i]);
         end
      end
   endtask

   task automatic test_neg_slow();
      int eb;
      logic [1:0] eo;
      apply(1, 1, 7'b0000001);
      for (int k = 1; k <= 256; k++) begin
         apply(1, 0, 7'b0000001);
         eb = (k < 256) ? -k : 0;
         eo = (k < 256) ? 2'b00 : 2'b01;
         vectors++;
         if (dut_bal() !== eb || neuron_out !== eo) begin
            miscompares++;
            $display("FAIL neg_slow[%0d]: got bal=%0d out=%b, expected bal=%0d out=%b",
                     k, dut_bal(), neuron_out, eb, eo);
         end
      end
   endtask

   task automatic test_restart();
      int exp_b [3] = '{263, 526, 767};
      apply(1, 1, 7'h7F);
      for (int i = 0; i < 5; i++) apply(1, 0, 7'h7F);
      apply(1, 1, 7'h7F);
      vectors++;
      if (dut_bal() !== 0 || neuron_out !== 2'b00) begin
         miscompares++;
         $display("FAIL restart_edge: got bal=%0d out=%b, expected bal=0 out=00", dut_bal(), neuron_out);
      end
      for (int i = 0; i < 3; i++) begin
         apply(1, 0, 7'h7F);
         vectors++;
         if (dut_bal() !== exp_b[i] || neuron_out !== 2'b10) begin
            miscompares++;
            $display("FAIL restart_seq[%0d]: got bal=%0d out=%b, expected bal=%0d out=10",
                     i, dut_bal(), neuron_out, exp_b[i]);
         end
      end
   endtask

   task automatic test_random();
      bit r, s;
      logic [HEIGHT-1:0] p;
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 99) != 0);
         s = ($urandom_range(0, 24) == 0);
         p = HEIGHT'($urandom);
         apply(r, s, p);
         vectors++;
         if (dut_bal() !== m_bal || int'(neuron_out) !== m_neu) begin
            miscompares++;
            $display("FAIL random[%0d]: got bal=%0d out=%b, expected bal=%0d out=%0d",
                     i, dut_bal(), neuron_out, m_bal, m_neu);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; pixels = 7'h7F;
      m_run = 0; m_bal = 0; m_neu = 0;
      test_reset();
      test_idle_hold();
      test_pos_small();
      test_saturate();
      test_neg_slow();
      test_restart();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/run_network.md
Name: run_network

Overview:
- Single-neuron-pair spiking perceptron.
- Each clock it takes one HEIGHT-bit column of binary pixels and sums the signed weights of the active pixels into a saturating membrane "balance".
- It emits a spike on the positive or negative output neuron whenever the balance crosses ±THRESHOLD.
- Sits under the image-loading controller, which pulses start before each sample and then streams pixel columns.

Parameters:
- WIDTH, 8, weight magnitude bits. Weights are WIDTH+1 bits, offset-binary; zero = 2^WIDTH, so 255→-1, 257→+1, 511→+255.
- HEIGHT, 7, number of pixel inputs / weights.
- WEIGHTS, HEIGHT x (WIDTH+1) unpacked array, all 2^WIDTH, weight for pixels[i] is WEIGHTS[i], index 0 leftmost.
- THRESHOLD, 256, spike threshold. Positive, < 2^(WIDTH+2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  synchronous pulse: clear balance and begin a sample
- pixels  input  HEIGHT  current pixel column, 1 = active
- neuron_out  output  2  registered spikes: bit1 = positive neuron, bit0 = negative neuron
- balance_out  output  WIDTH+3  registered signed two's-complement balance (11 bits at defaults)

Behaviour:
- States: IDLE, RUN.
- Reset (rst_n=0 at a rising edge; highest priority):
  - state = IDLE, balance_out = 0, neuron_out = 2'b00.
- IDLE:
  - Balance holds and neuron_out = 00. Pixels are ignored.
  - start=1 → balance = 0, neuron_out = 00, state = RUN.
- RUN, at each edge with start=0:
  - delta = sum over i with pixels[i]=1 of (WEIGHTS[i] - 2^WIDTH), computed at full width (≥ WIDTH+1+clog2(HEIGHT)+1 bits signed).
  - acc = balance + delta, saturated to [-2^(WIDTH+2), 2^(WIDTH+2)-1], i.e. [-1024, 1023] at defaults.
  - If acc ≥ THRESHOLD: balance = acc - THRESHOLD, neuron_out = 2'b10.
  - Else if acc ≤ -THRESHOLD: balance = acc + THRESHOLD, neuron_out = 2'b01.
  - Else: balance = acc, neuron_out = 00.
  - At most one spike, on one neuron, per cycle. 2'b11 is never produced.
- start=1 while in RUN: restarts the sample (balance = 0, outputs 00). No accumulation occurs that cycle.
- RUN persists until reset. There is no internal cycle limit; the controller decides the sample length.
- Latency:
  - The first accumulation occurs on the edge after the start edge.
  - Spike and balance for a column appear together, one edge after that column is sampled.
- pixels = 0 in RUN: delta = 0. Balance is unchanged unless it is already beyond threshold, in which case it spikes and relaxes toward 0.

Decomposition:
- Shared package snn_pkg:
  - balance width function (WIDTH+3).
  - offset-to-signed weight conversion function.
  - saturation bounds.
  - neuron_out encodings NEG=2'b01, POS=2'b10.
  - state enum {IDLE, RUN}.
- One sub-module, snn_weighted_sum: combinational signed sum of active offset-binary weights (parameters WIDTH, HEIGHT, WEIGHTS; ports pixels → delta).
- The top holds the FSM, the saturating accumulator and the threshold/spike logic.

Test Plan:
- Reset check: rst_n=0 for 2 edges with start=1 and pixels=7'h7F → balance_out=0, neuron_out=00; reset dominates start.
- pixels=7'b0000111 (delta=+255), start pulse, then RUN:
  - edge1 balance 255, out 00
  - edge2 balance 254, out 10
  - edge3 balance 253, out 10
- pixels=7'b1111111 (delta=+519), after start:
  - edge1 263 / 10
  - edge2 526 / 10
  - edge3 acc 1045 saturates to 1023 → 767 / 10
  - every later edge 767 / 10
- pixels=7'b0000001 (delta=-1), after start:
  - balance -1…-255 with out 00
  - edge256 acc -256 → balance 0, out 01
- Mid-run restart: after 5 RUN edges of the +519 case, pulse start → that edge balance 0 / 00, then the sequence restarts at 263.
- IDLE hold: after reset with pixels=7'h7F and no start for 20 edges → balance stays 0, neuron_out stays 00.
